// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage with mid-bit sampling, valid strobe and framing-error flag.
module uart_receiver #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int COUNTER_WIDTH  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_connection,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy,
    output logic [2:0] o_receive_state,
    output logic [2:0] o_bit_index
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
    localparam logic [COUNTER_WIDTH-1:0] HALF = COUNTER_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [COUNTER_WIDTH-1:0] FULL = COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);

    logic                     sync_q, rx_s_q;
    logic [2:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]               idx_q, idx_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: if (!rx_s_q) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d          = '0;
                shift_d[idx_q] = rx_s_q;
                idx_d          = idx_q + 3'd1;
                state_d        = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                state_d = rx_s_q ? IDLE : WAIT_HIGH;
                data_d  = rx_s_q ? shift_q : data_q;
                valid_d = rx_s_q;
                ferr_d  = !rx_s_q;
            end
            // a line held low after a bad stop bit must not start a new frame
            WAIT_HIGH: if (rx_s_q) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= serial_connection;
            rx_s_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data            = data_q;
    assign valid           = valid_q;
    assign framing_error   = ferr_q;
    assign busy            = state_q != IDLE;
    assign o_receive_state = state_q;
    assign o_bit_index     = idx_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed scenario tasks for the UART receive stage.
module tb_uart_receiver;
    localparam int C = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       serial_connection = 1'b1;
    logic [7:0] data;
    logic       valid, framing_error, busy;
    logic [2:0] o_receive_state, o_bit_index;

    int total = 0, bad = 0;
    int cyc = 0, vcount = 0, fcount = 0, both = 0, vlast = 0;
    int run = 0, maxrun = 0, t_start = 0;
    bit track = 1'b0;

    uart_receiver #(.CLOCKS_PER_BIT(C), .COUNTER_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .serial_connection(serial_connection),
        .data(data), .valid(valid), .framing_error(framing_error), .busy(busy),
        .o_receive_state(o_receive_state), .o_bit_index(o_bit_index)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid) begin
            vcount++;
            vlast = cyc;
        end
        if (framing_error) fcount++;
        if (valid && framing_error) both++;
        if (track) begin
            if (!busy) run++;
            else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        t_start = cyc;
        serial_connection = 1'b0;
        hold(C);
        for (int i = 0; i < 8; i++) begin
            serial_connection = b[i];
            hold(C);
        end
        serial_connection = stop;
        hold(C);
    endtask

    task automatic test_reset;
        int v0, f0;
        reset = 1'b1;
        serial_connection = 1'b1;
        hold(3);
        reset = 1'b0;
        total++;
        if ({data, valid, framing_error, busy, o_receive_state, o_bit_index} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b busy=%b st=%0d idx=%0d, want all 0",
                     data, valid, framing_error, busy, o_receive_state, o_bit_index);
        end
        v0 = vcount;
        f0 = fcount;
        hold(200);
        total++;
        if (vcount != v0 || fcount != f0 || o_receive_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_idle: got valid=%0d fe=%0d st=%0d, want 0 0 0",
                     vcount - v0, fcount - f0, o_receive_state);
        end
    endtask

    task automatic test_good_frame;
        int v0, f0;
        v0 = vcount;
        f0 = fcount;
        send_byte(8'hA5, 1'b1);
        hold(4);
        total++;
        if (vcount - v0 != 1) begin
            bad++;
            $display("FAIL good_valid_count: got %0d, want 1", vcount - v0);
        end
        total++;
        if (data !== 8'hA5) begin
            bad++;
            $display("FAIL good_data: got %h, want a5", data);
        end
        total++;
        if (fcount != f0) begin
            bad++;
            $display("FAIL good_no_ferr: got %0d, want 0", fcount - f0);
        end
        // two synchronizer cycles plus 153 cycles from rx_s falling
        total++;
        if (vlast - t_start != 155) begin
            bad++;
            $display("FAIL good_latency: got %0d, want 155", vlast - t_start);
        end
    endtask

    task automatic test_back_to_back;
        int v0, v1;
        logic [7:0] d1;
        v0 = vcount;
        run = 0;
        maxrun = 0;
        track = 1'b1;
        send_byte(8'h00, 1'b1);
        v1 = vlast;
        d1 = data;
        send_byte(8'hFF, 1'b1);
        hold(4);
        track = 1'b0;
        total++;
        if (d1 !== 8'h00) begin
            bad++;
            $display("FAIL b2b_first_data: got %h, want 00", d1);
        end
        total++;
        if (data !== 8'hFF) begin
            bad++;
            $display("FAIL b2b_second_data: got %h, want ff", data);
        end
        total++;
        if (vcount - v0 != 2 || vlast - v1 != 160) begin
            bad++;
            $display("FAIL b2b_spacing: got count=%0d gap=%0d, want 2 160", vcount - v0, vlast - v1);
        end
        total++;
        if (maxrun > C / 2) begin
            bad++;
            $display("FAIL b2b_busy_gap: got %0d idle cycles, want <= %0d", maxrun, C / 2);
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = vcount;
        f0 = fcount;
        serial_connection = 1'b0;
        hold(3);
        serial_connection = 1'b1;
        hold(1);
        total++;
        if (o_receive_state !== 3'd1) begin
            bad++;
            $display("FAIL glitch_start: got state %0d, want 1", o_receive_state);
        end
        hold(20);
        total++;
        if (o_receive_state !== 3'd0 || vcount != v0 || fcount != f0 || data !== 8'hFF) begin
            bad++;
            $display("FAIL glitch_reject: got st=%0d v=%0d fe=%0d data=%h, want 0 0 0 ff",
                     o_receive_state, vcount - v0, fcount - f0, data);
        end
    endtask

    task automatic test_framing_break;
        int v0, f0;
        v0 = vcount;
        f0 = fcount;
        send_byte(8'h3C, 1'b0);
        hold(40 * C);
        total++;
        if (fcount - f0 != 1 || vcount != v0) begin
            bad++;
            $display("FAIL ferr_pulse: got fe=%0d v=%0d, want 1 0", fcount - f0, vcount - v0);
        end
        total++;
        if (data !== 8'hFF) begin
            bad++;
            $display("FAIL ferr_data_kept: got %h, want ff", data);
        end
        total++;
        if (o_receive_state !== 3'd4) begin
            bad++;
            $display("FAIL ferr_wait_high: got state %0d, want 4", o_receive_state);
        end
        serial_connection = 1'b1;
        hold(4);
        total++;
        if (o_receive_state !== 3'd0) begin
            bad++;
            $display("FAIL break_release: got state %0d, want 0", o_receive_state);
        end
        send_byte(8'h3C, 1'b1);
        hold(4);
        total++;
        if (vcount - v0 != 1 || data !== 8'h3C || fcount - f0 != 1) begin
            bad++;
            $display("FAIL ferr_recover: got v=%0d data=%h fe=%0d, want 1 3c 1", vcount - v0, data, fcount - f0);
        end
    endtask

    task automatic test_mid_reset;
        int v0, f0;
        logic [7:0] b;
        b = 8'h5A;
        v0 = vcount;
        f0 = fcount;
        serial_connection = 1'b0;
        hold(C);
        for (int i = 0; i < 4; i++) begin
            serial_connection = b[i];
            hold(C);
        end
        total++;
        if (o_receive_state !== 3'd2 || o_bit_index !== 3'd4) begin
            bad++;
            $display("FAIL midreset_pre: got st=%0d idx=%0d, want 2 4", o_receive_state, o_bit_index);
        end
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        serial_connection = 1'b1;
        total++;
        if (o_receive_state !== 3'd0 || o_bit_index !== 3'd0 || busy !== 1'b0 || data !== 8'h00) begin
            bad++;
            $display("FAIL midreset_state: got st=%0d idx=%0d busy=%b data=%h, want 0 0 0 00",
                     o_receive_state, o_bit_index, busy, data);
        end
        hold(2 * C);
        total++;
        if (vcount != v0 || fcount != f0) begin
            bad++;
            $display("FAIL midreset_pulses: got v=%0d fe=%0d, want 0 0", vcount - v0, fcount - f0);
        end
        send_byte(8'h5A, 1'b1);
        hold(4);
        total++;
        if (vcount - v0 != 1 || data !== 8'h5A) begin
            bad++;
            $display("FAIL midreset_recover: got v=%0d data=%h, want 1 5a", vcount - v0, data);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_back_to_back;
        test_glitch;
        test_framing_break;
        test_mid_reset;
        total++;
        if (both != 0) begin
            bad++;
            $display("FAIL valid_ferr_overlap: got %0d cycles, want 0", both);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
